// File: rtl/rom_download_ctrl.sv
// rom_download_ctrl
// Steers the HPS ioctl byte stream into four on-chip ROM regions. It stalls
// the HPS with ioctl_wait until the target RAM takes each byte, captures the
// eight DIP-switch bytes, and keeps the game core in reset while a ROM image
// is loading and for a fixed settle time afterwards.
module rom_download_ctrl #(
  parameter logic [24:0] REG1_BASE = 25'h10000,
  parameter logic [24:0] REG2_BASE = 25'h20000,
  parameter logic [24:0] REG3_BASE = 25'h30000,
  parameter logic [24:0] ROM_END   = 25'h40000,
  parameter int          RADDR_W   = 16,
  parameter int          RST_HOLD  = 16
) (
  input  logic               i_clk,
  input  logic               reset,
  input  logic               ioctl_download,
  input  logic [7:0]         ioctl_index,
  input  logic               ioctl_wr,
  input  logic [24:0]        ioctl_addr,
  input  logic [7:0]         ioctl_dout,
  output logic               ioctl_wait,
  output logic [3:0]         rom_cs,
  output logic [RADDR_W-1:0] rom_addr,
  output logic [7:0]         rom_data,
  input  logic               rom_ready,
  output logic [63:0]        dsw,
  output logic               core_reset,
  output logic               rom_loaded,
  output logic               overflow
);

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RST_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_DIP = 8'd254;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  // One-hot region strobe for a linear MRA address; all zero past ROM_END.
  function automatic logic [3:0] region_cs(input logic [24:0] addr);
    logic [3:0] cs;
    if (addr < REG1_BASE) begin
      cs = 4'b0001;
    end else if (addr < REG2_BASE) begin
      cs = 4'b0010;
    end else if (addr < REG3_BASE) begin
      cs = 4'b0100;
    end else if (addr < ROM_END) begin
      cs = 4'b1000;
    end else begin
      cs = 4'b0000;
    end
    return cs;
  endfunction

  // First byte address of the region holding addr.
  function automatic logic [24:0] region_base(input logic [24:0] addr);
    logic [24:0] base;
    if (addr < REG1_BASE) begin
      base = 25'd0;
    end else if (addr < REG2_BASE) begin
      base = REG1_BASE;
    end else if (addr < REG3_BASE) begin
      base = REG2_BASE;
    end else begin
      base = REG3_BASE;
    end
    return base;
  endfunction

  state_t              state_r;
  state_t              state_s;
  logic [HOLD_W-1:0]   hold_cnt_r;

  logic                ioctl_wait_r;
  logic [3:0]          rom_cs_r;
  logic [RADDR_W-1:0]  rom_addr_r;
  logic [7:0]          rom_data_r;
  logic [7:0][7:0]     dsw_r;
  logic                core_reset_r;
  logic                rom_loaded_r;
  logic                overflow_r;

  logic                rom_dl_s;
  logic                byte_wr_s;
  logic                dip_wr_s;
  logic [3:0]          hit_cs_s;
  logic [RADDR_W-1:0]  offset_s;

  logic                start_dl_s;
  logic                load_byte_s;
  logic                write_done_s;
  logic                set_ovf_s;
  logic                hold_enter_s;
  logic                hold_done_s;

  // Decode the incoming ioctl beat: which kind of write it is and where it lands.
  always_comb begin
    rom_dl_s  = ioctl_download && (ioctl_index == IDX_ROM);
    byte_wr_s = ioctl_wr && (ioctl_index == IDX_ROM);
    dip_wr_s  = ioctl_wr && (ioctl_index == IDX_DIP) && (ioctl_addr[24:3] == 22'd0);
    hit_cs_s  = region_cs(ioctl_addr);
    offset_s  = RADDR_W'(ioctl_addr - region_base(ioctl_addr));
  end

  // Next-state logic and one-cycle control strobes for the download sequencer.
  always_comb begin
    state_s      = state_r;
    start_dl_s   = 1'b0;
    load_byte_s  = 1'b0;
    write_done_s = 1'b0;
    set_ovf_s    = 1'b0;
    hold_enter_s = 1'b0;
    hold_done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rom_dl_s) begin
          state_s    = ST_LOAD;
          start_dl_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // The end of the download wins over a byte arriving on the same beat.
        if (!ioctl_download) begin
          state_s      = ST_HOLD;
          hold_enter_s = 1'b1;
        end else if (byte_wr_s) begin
          if (hit_cs_s != 4'b0000) begin
            state_s     = ST_WRITE;
            load_byte_s = 1'b1;
          end else begin
            state_s   = ST_LOAD;
            set_ovf_s = 1'b1;
          end
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_WRITE: begin
        // Writes arriving here are HPS protocol violations and are dropped.
        if (rom_ready) begin
          write_done_s = 1'b1;
          if (ioctl_download) begin
            state_s = ST_LOAD;
          end else begin
            state_s      = ST_HOLD;
            hold_enter_s = 1'b1;
          end
        end else begin
          state_s = ST_WRITE;
        end
      end
      ST_HOLD: begin
        if (rom_dl_s) begin
          state_s    = ST_LOAD;
          start_dl_s = 1'b1;
        end else if (hold_cnt_r == HOLD_ZERO) begin
          state_s     = ST_IDLE;
          hold_done_s = 1'b1;
        end else begin
          state_s = ST_HOLD;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register and post-download reset hold counter.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      hold_cnt_r <= HOLD_ZERO;
    end else begin
      state_r <= state_s;
      if (hold_enter_s) begin
        hold_cnt_r <= HOLD_LOAD;
      end else if ((state_r == ST_HOLD) && (hold_cnt_r != HOLD_ZERO)) begin
        hold_cnt_r <= hold_cnt_r - HOLD_ONE;
      end else begin
        hold_cnt_r <= hold_cnt_r;
      end
    end
  end

  // ROM write port: latch a byte on acceptance, hold it until the RAM takes it.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      ioctl_wait_r <= 1'b0;
      rom_cs_r     <= 4'b0000;
      rom_addr_r   <= {RADDR_W{1'b0}};
      rom_data_r   <= 8'd0;
    end else if (load_byte_s) begin
      ioctl_wait_r <= 1'b1;
      rom_cs_r     <= hit_cs_s;
      rom_addr_r   <= offset_s;
      rom_data_r   <= ioctl_dout;
    end else if (write_done_s) begin
      ioctl_wait_r <= 1'b0;
      rom_cs_r     <= 4'b0000;
    end else begin
      ioctl_wait_r <= ioctl_wait_r;
      rom_cs_r     <= rom_cs_r;
    end
  end

  // Core reset, loaded flag and sticky out-of-range flag.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      core_reset_r <= 1'b1;
      rom_loaded_r <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      if (start_dl_s) begin
        core_reset_r <= 1'b1;
      end else if (hold_done_s) begin
        core_reset_r <= 1'b0;
      end else begin
        core_reset_r <= core_reset_r;
      end

      if (hold_done_s) begin
        rom_loaded_r <= 1'b1;
      end else begin
        rom_loaded_r <= rom_loaded_r;
      end

      if (start_dl_s) begin
        overflow_r <= 1'b0;
      end else if (set_ovf_s) begin
        overflow_r <= 1'b1;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  // DIP-switch bank capture, independent of the ROM sequencer.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      dsw_r <= {8{8'hFF}};
    end else if (dip_wr_s) begin
      dsw_r[ioctl_addr[2:0]] <= ioctl_dout;
    end else begin
      dsw_r <= dsw_r;
    end
  end

  assign ioctl_wait = ioctl_wait_r;
  assign rom_cs     = rom_cs_r;
  assign rom_addr   = rom_addr_r;
  assign rom_data   = rom_data_r;
  assign dsw        = dsw_r;
  assign core_reset = core_reset_r;
  assign rom_loaded = rom_loaded_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_rom_download_ctrl.sv
// Bench for rom_download_ctrl: directed downloads with literal expectations,
// plus a per-cycle comparison against a byte-level behavioural model.
module tb_rom_download_ctrl;

  localparam logic [24:0] ROM_END = 25'h40000;

  logic        i_clk = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic [3:0]  rom_cs;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rom_ready;
  logic [63:0] dsw;
  logic        core_reset;
  logic        rom_loaded;
  logic        overflow;

  int vectors = 0;
  int miscompares = 0;

  always #5 i_clk = ~i_clk;

  rom_download_ctrl dut (
    .i_clk          (i_clk),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .rom_cs         (rom_cs),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .rom_ready      (rom_ready),
    .dsw            (dsw),
    .core_reset     (core_reset),
    .rom_loaded     (rom_loaded),
    .overflow       (overflow)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a download session, at most one byte in flight,
  // the DIP bytes and the sticky out-of-range flag.
  logic            m_valid = 1'b0;
  logic            m_session;
  logic            m_pend;
  logic            m_ovf;
  logic [3:0]      m_cs;
  logic [15:0]     m_addr;
  logic [7:0]      m_data;
  logic [7:0][7:0] m_dsw;

  always @(posedge i_clk) begin
    if (reset) begin
      m_valid   <= 1'b1;
      m_session <= 1'b0;
      m_pend    <= 1'b0;
      m_ovf     <= 1'b0;
      m_cs      <= 4'b0000;
      m_dsw     <= {8{8'hFF}};
    end else if (m_valid) begin
      if (ioctl_wr && ioctl_index == 8'd254 && ioctl_addr < 25'd8)
        m_dsw[ioctl_addr[2:0]] <= ioctl_dout;
      if (!m_session) begin
        if (ioctl_download && ioctl_index == 8'd0) begin
          m_session <= 1'b1;
          m_ovf     <= 1'b0;
        end
      end else if (m_pend) begin
        if (rom_ready) begin
          m_pend <= 1'b0;
          if (!ioctl_download) m_session <= 1'b0;
        end
      end else if (!ioctl_download) begin
        m_session <= 1'b0;
      end else if (ioctl_wr && ioctl_index == 8'd0) begin
        if (ioctl_addr >= ROM_END) begin
          m_ovf <= 1'b1;
        end else begin
          m_pend <= 1'b1;
          m_cs   <= 4'b0001 << (ioctl_addr / 25'h10000);
          m_addr <= ioctl_addr[15:0];
          m_data <= ioctl_dout;
        end
      end
    end
  end

  // Compare DUT against the model on every cycle once reset has been seen.
  always @(negedge i_clk) begin
    if (m_valid) begin
      chk("model_wait", ioctl_wait, m_pend);
      chk("model_cs", rom_cs, m_pend ? m_cs : 4'b0000);
      if (m_pend) begin
        chk("model_addr", rom_addr, m_addr);
        chk("model_data", rom_data, m_data);
      end
      chk("model_dsw", dsw, m_dsw);
      chk("model_ovf", overflow, m_ovf);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_download = 1'b1;
    ioctl_index    = idx;
    tick(1);
  endtask

  task automatic put(input logic [24:0] a, input logic [7:0] d);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    tick(1);
    ioctl_wr   = 1'b0;
  endtask

  logic [24:0] t_addr [4] = '{25'h0, 25'h0FFFF, 25'h10000, 25'h3FFFF};
  logic [7:0]  t_data [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [3:0]  t_cs   [4] = '{4'b0001, 4'b0001, 4'b0010, 4'b1000};
  logic [15:0] t_radr [4] = '{16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};

  initial begin
    reset = 1'b1; ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
    ioctl_addr = 25'd0; ioctl_dout = 8'd0; rom_ready = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(5);
    chk("rst_core_reset", core_reset, 1'b1);
    chk("rst_rom_loaded", rom_loaded, 1'b0);
    chk("rst_dsw", dsw, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_wait", ioctl_wait, 1'b0);
    chk("rst_cs", rom_cs, 4'b0000);
    chk("rst_addr", rom_addr, 16'h0000);
    chk("rst_data", rom_data, 8'h00);
    chk("rst_overflow", overflow, 1'b0);

    // Region boundaries with the RAM always ready.
    start_dl(8'd0);
    chk("dl_core_reset", core_reset, 1'b1);
    for (int i = 0; i < 4; i++) begin
      put(t_addr[i], t_data[i]);
      chk("bnd_cs", rom_cs, t_cs[i]);
      chk("bnd_addr", rom_addr, t_radr[i]);
      chk("bnd_data", rom_data, t_data[i]);
      chk("bnd_wait", ioctl_wait, 1'b1);
      tick(1);
      chk("bnd_strobe_1cyc", rom_cs, 4'b0000);
      chk("bnd_wait_drop", ioctl_wait, 1'b0);
    end
    ioctl_download = 1'b0;
    tick(16);
    chk("hold_still_reset", core_reset, 1'b1);
    chk("hold_not_loaded", rom_loaded, 1'b0);
    tick(1);
    chk("hold_release", core_reset, 1'b0);
    chk("hold_loaded", rom_loaded, 1'b1);

    // Stalled write.
    start_dl(8'd0);
    chk("restart_core_reset", core_reset, 1'b1);
    rom_ready = 1'b0;
    put(25'h20005, 8'hA5);
    for (int i = 0; i < 7; i++) begin
      chk("stall_wait", ioctl_wait, 1'b1);
      chk("stall_cs", rom_cs, 4'b0100);
      chk("stall_addr", rom_addr, 16'h0005);
      tick(1);
    end
    rom_ready = 1'b1;
    tick(1);
    rom_ready = 1'b0;
    chk("stall_cs_drop", rom_cs, 4'b0000);
    chk("stall_wait_drop", ioctl_wait, 1'b0);

    // Out-of-range byte, then overflow cleared by a fresh download from HOLD.
    rom_ready = 1'b1;
    put(25'h40000, 8'hEE);
    chk("ovf_cs", rom_cs, 4'b0000);
    chk("ovf_wait", ioctl_wait, 1'b0);
    chk("ovf_set", overflow, 1'b1);
    tick(1);
    chk("ovf_sticky", overflow, 1'b1);
    ioctl_download = 1'b0;
    tick(3);
    chk("ovf_hold_reset", core_reset, 1'b1);
    start_dl(8'd0);
    chk("ovf_clear", overflow, 1'b0);
    chk("ovf_loaded_kept", rom_loaded, 1'b1);
    ioctl_download = 1'b0;
    tick(17);
    chk("ovf_release", core_reset, 1'b0);

    // DIP-switch capture.
    start_dl(8'd254);
    put(25'h1, 8'h5A);
    put(25'h7, 8'hC3);
    put(25'h8, 8'h00);
    chk("dip_wait", ioctl_wait, 1'b0);
    chk("dip_dsw", dsw, 64'hC3FF_FFFF_FFFF_5AFF);
    chk("dip_core_reset", core_reset, 1'b0);
    ioctl_download = 1'b0;
    ioctl_index = 8'd0;
    tick(2);
    chk("dip_core_reset_after", core_reset, 1'b0);

    // Download ends while a write is pending.
    start_dl(8'd0);
    rom_ready = 1'b0;
    put(25'h10002, 8'h77);
    chk("fall_cs", rom_cs, 4'b0010);
    ioctl_download = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("fall_pend_cs", rom_cs, 4'b0010);
      chk("fall_pend_wait", ioctl_wait, 1'b1);
    end
    rom_ready = 1'b1;
    tick(1);
    rom_ready = 1'b0;
    chk("fall_done_cs", rom_cs, 4'b0000);
    chk("fall_done_wait", ioctl_wait, 1'b0);
    chk("fall_hold_reset", core_reset, 1'b1);
    tick(15);
    chk("fall_hold_still", core_reset, 1'b1);
    tick(1);
    chk("fall_release", core_reset, 1'b0);

    // Reset in the middle of a pending write.
    start_dl(8'd0);
    put(25'h30010, 8'h99);
    chk("rw_cs", rom_cs, 4'b1000);
    chk("rw_addr", rom_addr, 16'h0010);
    chk("rw_wait", ioctl_wait, 1'b1);
    reset = 1'b1;
    tick(1);
    chk("rw_wait_drop", ioctl_wait, 1'b0);
    chk("rw_cs_drop", rom_cs, 4'b0000);
    chk("rw_core_reset", core_reset, 1'b1);
    chk("rw_loaded_clr", rom_loaded, 1'b0);
    chk("rw_dsw", dsw, 64'hFFFF_FFFF_FFFF_FFFF);
    reset = 1'b0;
    ioctl_download = 1'b0;
    tick(2);
    chk("rw_idle_reset", core_reset, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
